// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, status-register bit map and
// register offsets used by the FIFO and the register file.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam int RX_NOT_EMPTY = 0;
    localparam int RX_OVERFLOW  = 1;
    localparam int TX_BUSY      = 2;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CTRL   = 2'd3
    } uart_reg_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between UART receiver, RX FIFO and register file.
// master drives the push/pop requests, slave is the FIFO.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = 16
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LEVEL_W-1:0]    level;
    logic                  overflow;
    logic                  clear_overflow;
    logic                  flush;

    modport master (
        output in_data, in_valid, out_ready, clear_overflow, flush,
        input  in_ready, out_data, out_valid, level, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready, clear_overflow, flush,
        output in_ready, out_data, out_valid, level, overflow
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO, first-word-fall-through, drops on full and
// records the loss in a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = 16
) (
    input  logic            clk_in,
    input  logic            rst_n,
    uart_rx_fifo_if.slave   bus
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;
    localparam int ADDR_W  = LEVEL_W - 1;

    logic [LEVEL_W-1:0]    wr_ptr;
    logic [LEVEL_W-1:0]    rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  ovf_q;

    // MSB is the wrap bit: same low bits + different wrap = full
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[LEVEL_W-1] != rd_ptr[LEVEL_W-1]);

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = bus.in_valid & (~full | pop);
    // a byte lost to flush is not an overflow
    assign drop = bus.in_valid & full & ~pop & ~bus.flush;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + LEVEL_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (drop)
            ovf_q <= 1'b1;
        else if (bus.clear_overflow)
            ovf_q <= 1'b0;
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk_in  (clk_in),
        .wr_en   (push & ~bus.flush),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign bus.in_ready  = ~full | pop;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = rd_data & {DATA_WIDTH{~empty}};
    assign bus.level     = wr_ptr - rd_ptr;
    assign bus.overflow  = ovf_q;
endmodule
